// File: rtl/spi_master_ctrl.sv
// SPI master: serialises one 10-bit command per handshake as an 11-bit frame
// (select bit + cmd MSB first) and, for read-data commands, captures one MISO byte.
module spi_master_ctrl #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned GAP    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SHIFT, S_TURN, S_READ, S_GAP
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] payload;
  } cmd_t;

  localparam logic [1:0] OP_RD_DATA = 2'b11;
  localparam logic [3:0] TURN_LAST  = (RD_LAT > 0) ? 4'(RD_LAT - 1) : 4'd0;
  localparam logic [3:0] GAP_LAST   = (GAP > 1) ? 4'(GAP - 2) : 4'd0;
  // The IDLE cycle itself counts as the final gap cycle, so GAP=1 needs no GAP state.
  localparam state_e     POST_FRAME = (GAP > 1) ? S_GAP : S_IDLE;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [9:0]  cmd_bits;

  assign cmd_bits = cmd_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd_data;
          ss_n_d  = 1'b0;
          mosi_d  = cmd_data[9];
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        mosi_d  = cmd_q.op[1];
        cnt_d   = 4'd1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd10) begin
          mosi_d = 1'b0;
          cnt_d  = 4'd0;
          if (cmd_q.op == OP_RD_DATA) begin
            if (RD_LAT == 0) begin
              // No turnaround: this edge already takes the first data bit.
              shift_d = {shift_q[5:0], MISO};
              cnt_d   = 4'd1;
              state_d = S_READ;
            end else begin
              state_d = S_TURN;
            end
          end else begin
            ss_n_d  = 1'b1;
            state_d = POST_FRAME;
          end
        end else begin
          mosi_d = cmd_bits[4'd9 - cnt_q];
          cnt_d  = cnt_q + 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          // Edge leaving the turnaround is the first MISO sample edge.
          shift_d = {shift_q[5:0], MISO};
          cnt_d   = 4'd1;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd7) begin
          rd_data_d  = {shift_q, MISO};
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          cnt_d      = 4'd0;
          state_d    = POST_FRAME;
        end else begin
          shift_d = {shift_q[5:0], MISO};
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that sits directly upstream of the SPI slave. It drives SS_n and MOSI into the slave and captures MISO from it.
- Accepts one 10-bit command word (cmd[9:8] = opcode, cmd[7:0] = payload) per valid/ready handshake and serialises it as one SPI frame.
- For read-data commands (opcode 2'b11) it keeps SS_n low, waits out the slave/RAM turnaround, captures the 8 returned MISO bits and presents them as a byte with a one-cycle valid pulse.

Parameters:
RD_LAT, 1, cycles between the last command bit on MOSI and the first MISO data bit sampled; legal range 0..15.
GAP, 1, minimum cycles SS_n is held high between frames; legal range 1..7.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command word available.
cmd_ready  output  1  master idle and able to accept a command.
cmd_data  input  10  command word; [9:8] opcode, [7:0] address/data.
rd_data  output  8  byte captured from MISO on a read-data frame.
rd_valid  output  1  one-cycle pulse; rd_data is valid.
busy  output  1  frame or inter-frame gap in progress.
SS_n  output  1  slave select to SPI slave, active low.
MOSI  output  1  serial data to slave.
MISO  input  1  serial data from slave.

Behaviour:
- Reset (async assert): SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, busy=0, cmd_ready=1, state=IDLE, counters=0.
- Reset mid-frame aborts immediately: SS_n goes high asynchronously and no rd_valid is produced.
- Output timing: all outputs are registered. cmd_ready = (state==IDLE); busy = !cmd_ready.
- States: IDLE, CMD, SHIFT, TURN, READ, GAP.
- Acceptance edge T0 (cmd_valid & cmd_ready):
  - latch cmd_data into an internal register; later changes to cmd_data are ignored;
  - SS_n<=0, MOSI<=cmd[9], state IDLE->CMD.
- Frame bit 0 (the command-select bit) is cmd[9]. Frame bits 1..10 are cmd[9]..cmd[0], MSB first. Bit k is on MOSI during the cycle after edge Tk. Total 11 MOSI bits.
- CMD->SHIFT at T1.
- SHIFT runs T1..T10 with a 4-bit counter. At T10 the last bit (cmd[0]) is driven.
- At T11, opcode != 2'b11: SS_n<=1, MOSI<=0, state->GAP.
- At T11, opcode == 2'b11:
  - SS_n stays low, MOSI<=0;
  - state->TURN if RD_LAT>0, else state->READ.
- TURN lasts RD_LAT cycles. MISO is not sampled in TURN.
- READ samples MISO on 8 consecutive edges T(11+RD_LAT)..T(18+RD_LAT), MSB first, via shift register.
- On the 8th sample edge:
  - rd_data<={shift[6:0],MISO};
  - rd_valid<=1 for exactly one cycle;
  - SS_n<=1, state->GAP.
- GAP holds SS_n=1 for GAP cycles, then state->IDLE and cmd_ready=1.
- Back-to-back, default GAP=1: a non-read frame accepts the next command at T12. SS_n is high for exactly one cycle between frames.
- cmd_valid while busy: ignored, no acceptance. The requester must hold cmd_valid until the handshake.
- MISO outside READ is don't-care (may be X/Z) and must not affect any output.
- rd_data holds its value until the next read-data frame completes.

Test Plan:
- Write-address: cmd_data=10'b00_1010_0101, one-cycle cmd_valid.
  -> MOSI 0,0,0,1,0,1,0,0,1,0,1 over 11 cycles; SS_n low 11 cycles then high 1; cmd_ready back at T12; no rd_valid.
- Read-data: cmd_data=10'b11_0000_0000, RD_LAT=1; bench MISO model shifts 8'hC1 MSB first starting cycle 12.
  -> rd_data=8'hC1 with a single rd_valid pulse at T19; SS_n low T0..T18, high at T19.
- Back-to-back: cmd_valid held high with cmd 10'h0F3 then 10'h1F3.
  -> second frame starts at T12 with frame bit 0 = 0, then frame bits 1..10 = 0,1,1,1,1,1,0,0,1,1; SS_n high exactly one cycle between frames; first-word bits unaffected by the input change.
- Reset mid-frame: assert rst_n low during frame bit 5 of a read-data command.
  -> SS_n=1 and MOSI=0 immediately; no rd_valid; after release cmd_ready=1 and the next write frame is bit-exact.
- Loopback with SPI slave + single-port RAM, four commands: write-addr 0x35, write-data 0xA7, read-addr 0x35, read-data.
  -> rd_data=8'hA7, rd_valid once; MISO X outside READ never propagates to rd_data.
